// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch unit and the datapath: opcode values,
// fetch FSM state encoding and the one-hot operation flag bundle.
package isa_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MOV = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_LATCH = 2'd2,
      S_ISSUE = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic add;
      logic sub;
      logic mov;
      logic shl;
   } op_flags_t;

   // All-zero result marks an opcode with no defined operation.
   function automatic op_flags_t decode_op(input logic [2:0] opc);
      op_flags_t f;
      f = '0;
      case (opc)
         OP_ADD:  f.add = 1'b1;
         OP_SUB:  f.sub = 1'b1;
         OP_MOV:  f.mov = 1'b1;
         OP_SHL:  f.shl = 1'b1;
         default: f = '0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Program-ROM port and decoded-operation handshake between the fetch unit
// (master) and the ROM/datapath side (slave).
interface instr_fetch_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 11
);
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              op_valid;
   logic              op_ready;
   logic [2:0]        op_code;
   logic [7:0]        op_imm;
   logic              op_add;
   logic              op_sub;
   logic              op_mov;
   logic              op_shl;

   modport master (
      output rom_addr,
      input  rom_data,
      output op_valid,
      input  op_ready,
      output op_code,
      output op_imm,
      output op_add,
      output op_sub,
      output op_mov,
      output op_shl
   );

   modport slave (
      input  rom_addr,
      output rom_data,
      input  op_valid,
      output op_ready,
      input  op_code,
      input  op_imm,
      input  op_add,
      input  op_sub,
      input  op_mov,
      input  op_shl
   );
endinterface

// File: rtl/instr_decode.sv
// Combinational instruction decode: splits the word into opcode/immediate
// and produces the one-hot operation flags plus an illegal-opcode indication.
module instr_decode
   import isa_pkg::*;
#(
   parameter int DATA_W = 11
) (
   input  logic [DATA_W-1:0] ir,
   output logic [2:0]        op_code,
   output logic [7:0]        op_imm,
   output op_flags_t         flags,
   output logic              illegal
);

   // Field split and opcode lookup.
   always_comb begin
      op_code = ir[10:8];
      op_imm  = ir[7:0];
      flags   = decode_op(ir[10:8]);
      illegal = (flags == '0);
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/issue controller for a registered program ROM.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | parked, waiting for en
//   S_FETCH | PC presented to the ROM; ROM registers the address
//   S_LATCH | ROM word valid; captured into IR, illegal words skipped
//   S_ISSUE | op_valid high, IR held until op_ready
module instr_fetch
   import isa_pkg::*;
#(
   parameter int ADDR_W   = 3,
   parameter int DATA_W   = 11,
   parameter int PROG_LEN = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   instr_fetch_if.master bus,
   output logic          pc_wrap,
   output logic          illegal
);

   localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(PROG_LEN - 1);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] dec_in;
   logic              advance;
   logic              set_illegal;
   logic              issue;
   logic              pc_wrap_q;

   logic [2:0]        dec_code;
   logic [7:0]        dec_imm;
   op_flags_t         dec_flags;
   logic              dec_illegal;

   // In LATCH the decoder looks at the fresh ROM word so the legality
   // decision is made the same cycle it is captured; otherwise it shows IR.
   assign dec_in = (state == S_LATCH) ? bus.rom_data : ir;

   instr_decode #(
      .DATA_W (DATA_W)
   ) u_decode (
      .ir      (dec_in),
      .op_code (dec_code),
      .op_imm  (dec_imm),
      .flags   (dec_flags),
      .illegal (dec_illegal)
   );

   // Next-state, PC advance and issue decisions.
   always_comb begin
      state_nxt   = state;
      advance     = 1'b0;
      set_illegal = 1'b0;
      issue       = 1'b0;
      case (state)
         S_IDLE: begin
            if (en) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            state_nxt = S_LATCH;
         end
         S_LATCH: begin
            if (dec_illegal) begin
               set_illegal = 1'b1;
               advance     = 1'b1;
               state_nxt   = en ? S_FETCH : S_IDLE;
            end else begin
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // Masked during reset so a pending operation is never accepted.
            issue = ~rst;
            if (issue && bus.op_ready) begin
               advance   = 1'b1;
               state_nxt = en ? S_FETCH : S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State, PC, IR and sticky flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         pc        <= '0;
         ir        <= '0;
         illegal   <= 1'b0;
         pc_wrap_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         pc_wrap_q <= advance && (pc == PC_LAST);
         if (advance) pc <= (pc == PC_LAST) ? '0 : pc + ADDR_W'(1);
         if (state == S_LATCH) ir <= bus.rom_data;
         if (set_illegal) illegal <= 1'b1;
      end
   end

   assign bus.rom_addr = pc;
   assign bus.op_valid = issue;
   assign bus.op_code  = dec_code;
   assign bus.op_imm   = dec_imm;
   assign bus.op_add   = issue & dec_flags.add;
   assign bus.op_sub   = issue & dec_flags.sub;
   assign bus.op_mov   = issue & dec_flags.mov;
   assign bus.op_shl   = issue & dec_flags.shl;
   assign pc_wrap      = pc_wrap_q & ~rst;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: registered ROM model, transaction-level reference
// (expected issue order, skip count, wrap events) and directed en/reset cases.
module tb_instr_fetch;

   localparam int ADDR_W   = 3;
   localparam int DATA_W   = 11;
   localparam int PROG_LEN = 8;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic pc_wrap;
   logic illegal;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DATA_W-1:0] rom       [PROG_LEN];
   logic [DATA_W-1:0] base_prog [PROG_LEN];

   int m_pc;
   bit m_ill;

   instr_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   instr_fetch #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .PROG_LEN (PROG_LEN)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .bus     (bus),
      .pc_wrap (pc_wrap),
      .illegal (illegal)
   );

   always #5 clk = ~clk;

   // Registered program ROM: data appears the cycle after the address.
   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rom_word(input int i);
      return rom[i[ADDR_W-1:0]];
   endfunction

   function automatic bit legal_op(input logic [2:0] opc);
      return (opc == 3'd0) || (opc == 3'd1) || (opc == 3'd4) || (opc == 3'd5);
   endfunction

   // {add, sub, mov, shl}
   function automatic logic [3:0] exp_flags(input logic [2:0] opc);
      case (opc)
         3'd0:    return 4'b1000;
         3'd1:    return 4'b0100;
         3'd4:    return 4'b0010;
         3'd5:    return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   // Advance the model PC; returns 1 when it wraps.
   function automatic bit m_step();
      if (m_pc == PROG_LEN - 1) begin
         m_pc = 0;
         return 1'b1;
      end
      m_pc = m_pc + 1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_pc  = 0;
      m_ill = 1'b0;
   endtask

   // Leaves the bench at a falling edge with rst just released and en=1.
   task automatic do_reset();
      rst          = 1'b1;
      en           = 1'b1;
      bus.op_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_op_valid", 32'(bus.op_valid), 0);
      check("rst_rom_addr", 32'(bus.rom_addr), 0);
      check("rst_pc_wrap", 32'(pc_wrap), 0);
      check("rst_illegal", 32'(illegal), 0);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!bus.op_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_timeout"}, 32'(bus.op_valid), 1);
   endtask

   // Runs with en=1 from a freshly released reset. stall_n<0: random
   // op_ready; otherwise op_ready held low for stall_n cycles of each issue.
   task automatic run_model(input int ncycles, input int stall_n);
      int         gap = -1;
      int         gap_wraps = 0;
      int         exp_gap_wraps = 0;
      int         skips;
      int         stall = 0;
      bit         seen = 1'b0;
      bit         chk_wrap = 1'b0;
      bit         exp_wrap = 1'b0;
      logic [2:0] e_code;
      for (int c = 0; c < ncycles; c++) begin
         if (chk_wrap) begin
            check("pc_wrap_pulse", 32'(pc_wrap), 32'(exp_wrap));
            chk_wrap = 1'b0;
         end
         if (bus.op_valid) begin
            if (!seen) begin
               skips = 0;
               while (!legal_op(rom_word(m_pc)[10:8]) && skips < PROG_LEN) begin
                  m_ill = 1'b1;
                  if (m_step()) exp_gap_wraps++;
                  skips++;
               end
               check("issue_gap", 32'(gap), 32'(2 + 2 * skips));
               check("gap_wrap_pulses", 32'(gap_wraps), 32'(exp_gap_wraps));
               check("illegal_flag", 32'(illegal), 32'(m_ill));
               seen  = 1'b1;
               stall = 0;
            end
            e_code = rom_word(m_pc)[10:8];
            check("rom_addr", 32'(bus.rom_addr), 32'(m_pc));
            check("op_code", 32'(bus.op_code), 32'(e_code));
            check("op_imm", 32'(bus.op_imm), 32'(rom_word(m_pc)[7:0]));
            check("op_flags", 32'({bus.op_add, bus.op_sub, bus.op_mov, bus.op_shl}),
                  32'(exp_flags(e_code)));
            if (stall_n < 0) bus.op_ready = ($urandom_range(0, 2) != 0);
            else             bus.op_ready = (stall >= stall_n);
            stall++;
            if (bus.op_ready) begin
               seen          = 1'b0;
               gap           = 0;
               gap_wraps     = 0;
               exp_wrap      = m_step();
               chk_wrap      = 1'b1;
               exp_gap_wraps = exp_wrap ? 1 : 0;
            end
         end else begin
            check("flags_idle", 32'({bus.op_add, bus.op_sub, bus.op_mov, bus.op_shl}), 0);
            if (pc_wrap) gap_wraps++;
            gap++;
            bus.op_ready = (stall_n < 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      base_prog = '{11'h400, 11'h070, 11'h10C, 11'h502, 11'h400, 11'h080, 11'h080, 11'h400};
      rom          = base_prog;
      rst          = 1'b1;
      en           = 1'b1;
      bus.op_ready = 1'b0;

      // Full program at 3-cycle spacing through a wrap.
      do_reset();
      run_model(36, 0);

      // Back-pressure: 5 stalled cycles on every issue.
      do_reset();
      run_model(40, 5);

      // Illegal word at address 2 is skipped.
      rom[2] = 11'h30C;
      do_reset();
      run_model(30, 0);

      // en dropped during LATCH of address 1.
      rom = base_prog;
      do_reset();
      bus.op_ready = 1'b1;
      repeat (5) @(negedge clk);
      check("en_latch1_addr", 32'(bus.rom_addr), 1);
      check("en_latch1_valid", 32'(bus.op_valid), 0);
      en = 1'b0;
      @(negedge clk);
      check("en_issue_valid", 32'(bus.op_valid), 1);
      check("en_issue_code", 32'(bus.op_code), 0);
      check("en_issue_imm", 32'(bus.op_imm), 32'h70);
      check("en_issue_add", 32'(bus.op_add), 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("en_idle_valid", 32'(bus.op_valid), 0);
         check("en_idle_addr", 32'(bus.rom_addr), 2);
      end
      en = 1'b1;
      wait_valid("en_resume");
      check("en_resume_code", 32'(bus.op_code), 1);
      check("en_resume_imm", 32'(bus.op_imm), 12);

      // Reset in the middle of an ISSUE, with op_ready high.
      rom    = base_prog;
      rom[1] = 11'h600;
      do_reset();
      wait_valid("rst_mov0");
      bus.op_ready = 1'b1;
      @(negedge clk);
      bus.op_ready = 1'b0;
      wait_valid("rst_sub12");
      check("rst_sub12_imm", 32'(bus.op_imm), 12);
      check("rst_sub12_code", 32'(bus.op_code), 1);
      check("rst_pre_illegal", 32'(illegal), 1);
      rst          = 1'b1;
      bus.op_ready = 1'b1;
      @(negedge clk);
      check("rst_mid_valid", 32'(bus.op_valid), 0);
      check("rst_mid_addr", 32'(bus.rom_addr), 0);
      check("rst_mid_illegal", 32'(illegal), 0);
      rst = 1'b0;
      rom = base_prog;
      model_reset();
      run_model(12, 0);

      // Random programs with random back-pressure.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < PROG_LEN; i++) rom[i[ADDR_W-1:0]] = DATA_W'($urandom);
         rom[0][10:8] = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'd5;
         do_reset();
         run_model(500, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
